// File: rtl/rd_empty_ctrl.sv
// Read-side control for the dual-clock FIFO: read pointer, write-pointer synchronizer,
// and registered empty / almost_empty / level flags with the storage read address.
module rd_empty_ctrl #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 1
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         rd_en,
  input  logic [$clog2(DEPTH)-1:0]     wr_ptr_gray,
  output logic [$clog2(DEPTH)-1:0]     rd_ptr_gray,
  output logic [$clog2(DEPTH)-2:0]     rd_addr,
  output logic                         rd_valid,
  output logic                         empty,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH)-1:0]     rd_level,
  output logic                         underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW:0] AE_LIM = (PW+1)'(AE_THRESH);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rgray_q, rgray_d;
  logic          empty_q, empty_d;
  logic          ae_q, ae_d;
  logic [PW-1:0] level_q, level_d;
  logic          rvld_q;
  logic          uflow_q, uflow_d;
  logic          pop;
  logic [PW-1:0] wq_gray;
  logic [PW-1:0] wbin;

  // Plain flop chain: only Gray values cross, so no logic may sit between stages.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= wr_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wq_gray = sync_q[SYNC_STAGES-1];
  assign wbin    = gray2bin(wq_gray);

  // Flags come from next-state pointers so empty rises right after the final pop.
  always_comb begin
    pop     = rd_en & ~empty_q;
    rbin_d  = rbin_q + PW'(pop);
    rgray_d = rbin_d ^ (rbin_d >> 1);
    level_d = wbin - rbin_d;
    empty_d = (rgray_d == wq_gray);
    ae_d    = ({1'b0, level_d} <= AE_LIM);
    uflow_d = uflow_q | (rd_en & empty_q);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rbin_q  <= '0;
      rgray_q <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
      level_q <= '0;
      rvld_q  <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      empty_q <= empty_d;
      ae_q    <= ae_d;
      level_q <= level_d;
      rvld_q  <= pop;
      uflow_q <= uflow_d;
    end
  end

  // Storage read is synchronous: address during the pop cycle, data one cycle later.
  assign rd_addr      = rbin_q[AW-1:0];
  assign rd_ptr_gray  = rgray_q;
  assign rd_valid     = rvld_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign rd_level     = level_q;
  assign underflow    = uflow_q;

endmodule

// File: tb/tb_rd_empty_ctrl.sv
// Bench for rd_empty_ctrl: directed scenarios plus random traffic against a counting model.
module tb_rd_empty_ctrl;

  localparam int SYNC = 2;

  logic       clock = 1'b0;
  logic       resetn;
  logic       rd_en;
  logic [2:0] w_cnt;
  logic [2:0] wr_ptr_gray;
  logic [2:0] rd_ptr_gray;
  logic [1:0] rd_addr;
  logic       rd_valid, empty, almost_empty, underflow;
  logic [2:0] rd_level;

  int checks = 0;
  int errors = 0;

  // Reference model: pop count, a delay line of write counts, and derived flags.
  logic [2:0] m_rd;
  logic [2:0] m_hist [SYNC];
  logic       m_empty, m_ae, m_rvld, m_uf;
  logic [2:0] m_level;

  function automatic logic [2:0] g(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  assign wr_ptr_gray = g(w_cnt);

  always #5 clock = ~clock;

  rd_empty_ctrl #(.DEPTH(8), .SYNC_STAGES(SYNC), .AE_THRESH(1)) dut (
    .clock(clock), .resetn(resetn), .rd_en(rd_en), .wr_ptr_gray(wr_ptr_gray),
    .rd_ptr_gray(rd_ptr_gray), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .empty(empty), .almost_empty(almost_empty), .rd_level(rd_level),
    .underflow(underflow)
  );

  function automatic logic [11:0] obs();
    return {empty, almost_empty, rd_level, rd_ptr_gray, rd_addr, rd_valid, underflow};
  endfunction

  function automatic logic [11:0] expv();
    return {m_empty, m_ae, m_level, g(m_rd), m_rd[1:0], m_rvld, m_uf};
  endfunction

  task automatic tick();
    logic [2:0] wseen;
    logic       pop;
    @(posedge clock);
    if (!resetn) begin
      for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
      m_rd = 0; m_empty = 1; m_ae = 1; m_level = 0; m_rvld = 0; m_uf = 0;
    end else begin
      wseen = m_hist[SYNC-1];
      pop   = rd_en && !m_empty;
      if (rd_en && m_empty) m_uf = 1;
      m_rd    = m_rd + 3'(pop);
      m_level = wseen - m_rd;
      m_empty = (m_level == 0);
      m_ae    = (m_level <= 1);
      m_rvld  = pop;
      for (int k = SYNC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = w_cnt;
    end
    #1;
  endtask

  task automatic test_reset();
    resetn = 0; rd_en = 0; w_cnt = 0;
    tick(); tick();
    checks++;
    if (obs() !== 12'b1_1_000_000_00_0_0) begin
      errors++;
      $display("FAIL reset_state got=%b want=%b", obs(), 12'b1_1_000_000_00_0_0);
    end
    resetn = 1;
  endtask

  task automatic test_single_write();
    w_cnt = 1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (empty !== (c < 3) || rd_level !== (c < 3 ? 3'd0 : 3'd1) || almost_empty !== 1'b1) begin
        errors++;
        $display("FAIL single_write cyc=%0d got e=%b lvl=%0d ae=%b want e=%b lvl=%0d ae=1",
                 c, empty, rd_level, almost_empty, c < 3, c < 3 ? 0 : 1);
      end
    end
  endtask

  task automatic test_drain4();
    logic [2:0] exp_g [4];
    exp_g = '{3'b001, 3'b011, 3'b010, 3'b110};
    for (int w = 2; w <= 4; w++) begin w_cnt = 3'(w); tick(); end
    tick(); tick(); tick();
    checks++;
    if (rd_level !== 3'd4 || almost_empty !== 1'b0 || empty !== 1'b0) begin
      errors++;
      $display("FAIL drain_level got lvl=%0d ae=%b e=%b want lvl=4 ae=0 e=0", rd_level, almost_empty, empty);
    end
    rd_en = 1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_addr !== 2'(i)) begin
        errors++;
        $display("FAIL drain_addr pop=%0d got=%0d want=%0d", i, rd_addr, i);
      end
      tick();
      checks++;
      if (rd_ptr_gray !== exp_g[i] || rd_valid !== 1'b1 || almost_empty !== (i >= 2) || empty !== (i == 3)) begin
        errors++;
        $display("FAIL drain_pop pop=%0d got g=%b v=%b ae=%b e=%b want g=%b v=1 ae=%b e=%b",
                 i, rd_ptr_gray, rd_valid, almost_empty, empty, exp_g[i], i >= 2, i == 3);
      end
    end
    rd_en = 0;
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_level !== 3'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_end got v=%b lvl=%0d e=%b want v=0 lvl=0 e=1", rd_valid, rd_level, empty);
    end
  endtask

  task automatic test_wrap();
    logic [2:0] exp_g [3];
    logic [1:0] exp_a [3];
    exp_g = '{3'b100, 3'b000, 3'b001};
    exp_a = '{2'd2, 2'd3, 2'd0};
    w_cnt = 5; tick(); w_cnt = 6; tick(); tick(); tick(); tick();
    rd_en = 1; tick(); tick(); rd_en = 0;
    checks++;
    if (rd_ptr_gray !== 3'b101 || empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_setup got g=%b e=%b want g=101 e=1", rd_ptr_gray, empty);
    end
    w_cnt = 7; tick(); w_cnt = 0; tick(); w_cnt = 1; tick(); tick(); tick(); tick();
    checks++;
    if (rd_level !== 3'd3 || empty !== 1'b0) begin
      errors++;
      $display("FAIL wrap_level got lvl=%0d e=%b want lvl=3 e=0", rd_level, empty);
    end
    rd_en = 1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_addr !== exp_a[i]) begin
        errors++;
        $display("FAIL wrap_addr pop=%0d got=%0d want=%0d", i, rd_addr, exp_a[i]);
      end
      tick();
      checks++;
      if (rd_ptr_gray !== exp_g[i] || empty !== (i == 2)) begin
        errors++;
        $display("FAIL wrap_pop pop=%0d got g=%b e=%b want g=%b e=%b", i, rd_ptr_gray, empty, exp_g[i], i == 2);
      end
    end
    rd_en = 0;
  endtask

  task automatic test_underflow();
    rd_en = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rd_ptr_gray !== 3'b001 || rd_valid !== 1'b0 || underflow !== 1'b1) begin
        errors++;
        $display("FAIL underflow_req cyc=%0d got g=%b v=%b uf=%b want g=001 v=0 uf=1", i, rd_ptr_gray, rd_valid, underflow);
      end
    end
    rd_en = 0;
    tick(); tick();
    checks++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow_hold got=%b want=1", underflow);
    end
  endtask

  task automatic test_reset_mid();
    for (int w = 2; w <= 4; w++) begin w_cnt = 3'(w); tick(); end
    tick(); tick(); tick();
    checks++;
    if (rd_level !== 3'd3) begin
      errors++;
      $display("FAIL mid_level got=%0d want=3", rd_level);
    end
    rd_en = 1; tick();
    resetn = 0; w_cnt = 0; tick();
    checks++;
    if (obs() !== 12'b1_1_000_000_00_0_0) begin
      errors++;
      $display("FAIL mid_reset got=%b want=%b", obs(), 12'b1_1_000_000_00_0_0);
    end
    resetn = 1; rd_en = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (empty !== 1'b1 || rd_level !== 3'd0) begin
        errors++;
        $display("FAIL mid_after cyc=%0d got e=%b lvl=%0d want e=1 lvl=0", i, empty, rd_level);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] diff;
    for (int c = 0; c < 600; c++) begin
      diff   = w_cnt - m_rd;
      rd_en  = 1'($urandom_range(0, 1));
      resetn = ($urandom_range(0, 99) != 0);
      if (!resetn) w_cnt = 0;
      else if (diff < 4 && $urandom_range(0, 2) != 0) w_cnt = w_cnt + 3'd1;
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b want=%b", c, obs(), expv());
      end
    end
    resetn = 1; rd_en = 0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_drain4();
    test_wrap();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
